quad_mouse_to_ps2: RTL and testbench



---
 rtl/quad_mouse_to_ps2.sv | 168 ++++++++++++++++
 tb/tb_quad_mouse_to_ps2.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_mouse_to_ps2.sv
// Atari ST-style quadrature mouse to 25-bit PS/2 mouse packet converter.
// Optional build macro QUAD_GLITCH_FILTER_EN adds a 3-sample majority filter on the phase inputs.
module quad_mouse_to_ps2 #(
    parameter int unsigned REPORT_DIV = 4096,
    parameter int unsigned STEP       = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [1:0]  xin,
    input  logic [1:0]  yin,
    input  logic        button_l,
    input  logic        button_r,
    input  logic        button_m,
    output logic [24:0] ps2_mouse,
    output logic        quad_error
);

    localparam int unsigned TW = $clog2(REPORT_DIV);
    localparam logic [TW-1:0] TIMER_MAX = TW'(REPORT_DIV - 1);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] ACC_MAX = 11'sd255;
    localparam logic signed [10:0] ACC_MIN = -11'sd256;

    typedef enum logic [1:0] {StepNone, StepPos, StepNeg, StepBad} step_e;

    function automatic step_e decode(input logic [1:0] p, input logic [1:0] c);
        step_e s;
        case ({p, c})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: s = StepNeg;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: s = StepPos;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: s = StepBad;
            default:                            s = StepNone;
        endcase
        return s;
    endfunction

    // Returns {overflow, next accumulator}; the result is clamped to -256..+255.
    function automatic logic [10:0] accumulate(input logic [9:0] acc, input step_e s);
        logic signed [10:0] sum;
        logic               ovf;
        sum = {acc[9], acc};
        ovf = 1'b0;
        case (s)
            StepPos: sum = sum + STEP_S;
            StepNeg: sum = sum - STEP_S;
            default: sum = sum;
        endcase
        if (sum > ACC_MAX) begin
            sum = ACC_MAX;
            ovf = 1'b1;
        end else if (sum < ACC_MIN) begin
            sum = ACC_MIN;
            ovf = 1'b1;
        end
        return {ovf, sum[9:0]};
    endfunction

    logic [6:0]    raw;
    logic [6:0]    sync1_q, sync2_q;
    logic [3:0]    phase;
    logic [1:0]    px_q, py_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [9:0]    x_acc_q, x_acc_d, y_acc_q, y_acc_d;
    logic [9:0]    x_base, y_base;
    logic          x_ov_q, x_ov_d, y_ov_q, y_ov_d;
    logic          x_ovf_step, y_ovf_step;
    logic [2:0]    btn_sync;
    logic [2:0]    btn_prev_q, btn_prev_d;
    logic          err_q, err_d;
    logic          emit_q, emit_d;
    logic [23:0]   pkt_q, pkt_d;
    logic [24:0]   ps2_q, ps2_d;
    logic          wrap;
    step_e         x_step, y_step;

    assign raw      = {button_m, button_r, button_l, yin, xin};
    assign btn_sync = sync2_q[6:4];

`ifdef QUAD_GLITCH_FILTER_EN
    logic [3:0] f0_q, f1_q, f2_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            f0_q <= raw[3:0];
            f1_q <= raw[3:0];
            f2_q <= raw[3:0];
        end else if (ce) begin
            f0_q <= sync2_q[3:0];
            f1_q <= f0_q;
            f2_q <= f1_q;
        end
    end

    assign phase = (f0_q & f1_q) | (f0_q & f2_q) | (f1_q & f2_q);
`else
    assign phase = sync2_q[3:0];
`endif

    always_comb begin
        x_step     = ce ? decode(px_q, phase[1:0]) : StepNone;
        y_step     = ce ? decode(py_q, phase[3:2]) : StepNone;
        wrap       = ce && (timer_q == TIMER_MAX);
        timer_d    = timer_q;
        if (ce) begin
            timer_d = wrap ? '0 : timer_q + 1'b1;
        end

        // A step decoded in the wrap cycle seeds the next report rather than this one.
        x_base = wrap ? '0 : x_acc_q;
        y_base = wrap ? '0 : y_acc_q;
        {x_ovf_step, x_acc_d} = accumulate(x_base, x_step);
        {y_ovf_step, y_acc_d} = accumulate(y_base, y_step);
        x_ov_d = (x_ov_q & ~wrap) | x_ovf_step;
        y_ov_d = (y_ov_q & ~wrap) | y_ovf_step;

        err_d = err_q | (x_step == StepBad) | (y_step == StepBad);

        emit_d = wrap && ((x_acc_q != '0) || (y_acc_q != '0) || x_ov_q || y_ov_q ||
                          (btn_sync != btn_prev_q));
        pkt_d = emit_d ? {y_acc_q[7:0], x_acc_q[7:0], y_ov_q, x_ov_q, y_acc_q[8], x_acc_q[8],
                          1'b1, ~btn_sync[2], ~btn_sync[1], ~btn_sync[0]}
                       : pkt_q;
        btn_prev_d = wrap ? btn_sync : btn_prev_q;
        ps2_d      = emit_q ? {~ps2_q[24], pkt_q} : ps2_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Loading from the raw pins keeps the first decode after reset step-free.
            sync1_q    <= raw;
            sync2_q    <= raw;
            px_q       <= raw[1:0];
            py_q       <= raw[3:2];
            timer_q    <= '0;
            x_acc_q    <= '0;
            y_acc_q    <= '0;
            x_ov_q     <= 1'b0;
            y_ov_q     <= 1'b0;
            btn_prev_q <= 3'b111;
            err_q      <= 1'b0;
            emit_q     <= 1'b0;
            pkt_q      <= '0;
            ps2_q      <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            if (ce) begin
                px_q <= phase[1:0];
                py_q <= phase[3:2];
            end
            timer_q    <= timer_d;
            x_acc_q    <= x_acc_d;
            y_acc_q    <= y_acc_d;
            x_ov_q     <= x_ov_d;
            y_ov_q     <= y_ov_d;
            btn_prev_q <= btn_prev_d;
            err_q      <= err_d;
            emit_q     <= emit_d;
            pkt_q      <= pkt_d;
            ps2_q      <= ps2_d;
        end
    end

    assign ps2_mouse  = ps2_q;
    assign quad_error = err_q;

endmodule

// File: tb/tb_quad_mouse_to_ps2.sv
// Scoreboard bench for quad_mouse_to_ps2: one instance with STEP=1, one with STEP=16.
module tb_quad_mouse_to_ps2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b1;
    logic [1:0]  xin1 = 2'b00, yin1 = 2'b00, xin16 = 2'b00, yin16 = 2'b00;
    logic        bl1 = 1'b1, br1 = 1'b1, bm1 = 1'b1;
    logic        bl16 = 1'b1, br16 = 1'b1, bm16 = 1'b1;
    logic [24:0] ps2_1, ps2_16;
    logic        qe1, qe16;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rx1 = 0;
    int rx16 = 0;
    int rx_before;
    logic [24:0] q1[$];
    logic [24:0] q16[$];
    logic tog1 = 1'b0, tog16 = 1'b0;

    always #5 clk = ~clk;

    quad_mouse_to_ps2 #(.REPORT_DIV(16), .STEP(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .xin(xin1), .yin(yin1),
        .button_l(bl1), .button_r(br1), .button_m(bm1),
        .ps2_mouse(ps2_1), .quad_error(qe1)
    );

    quad_mouse_to_ps2 #(.REPORT_DIV(32), .STEP(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .xin(xin16), .yin(yin16),
        .button_l(bl16), .button_r(br16), .button_m(bm16),
        .ps2_mouse(ps2_16), .quad_error(qe16)
    );

    // Reference count of ce pulses since reset; report phase is cyc modulo the period.
    always @(posedge clk) begin
        if (!reset_n) cyc <= 0;
        else if (ce) cyc <= cyc + 1;
    end

    function automatic logic [1:0] pos_next(input logic [1:0] c);
        case (c)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp_v);
        end
    endtask

    task automatic push1(input logic [23:0] p);
        tog1 = ~tog1;
        q1.push_back({tog1, p});
    endtask

    task automatic push16(input logic [23:0] p);
        tog16 = ~tog16;
        q16.push_back({tog16, p});
    endtask

    task automatic wait_phase(input int m, input int v);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (((cyc % m) != v) && (n < 200));
        if ((cyc % m) != v) begin
            checks++;
            errors++;
            $display("FAIL wait_phase: got phase %0d required %0d", cyc % m, v);
        end
    endtask

    // Monitor: every toggle of bit 24 is one packet, compared against the queue head.
    initial begin
        logic        last1, last16;
        logic [24:0] exp_pkt;
        last1  = 1'b0;
        last16 = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last1  = 1'b0;
                last16 = 1'b0;
            end else begin
                if (ps2_1[24] !== last1) begin
                    last1 = ps2_1[24];
                    rx1++;
                    checks++;
                    if (q1.size() == 0) begin
                        errors++;
                        $display("FAIL pkt1: got %h required no packet", ps2_1);
                    end else begin
                        exp_pkt = q1.pop_front();
                        if (ps2_1 !== exp_pkt) begin
                            errors++;
                            $display("FAIL pkt1: got %h required %h", ps2_1, exp_pkt);
                        end
                    end
                end
                if (ps2_16[24] !== last16) begin
                    last16 = ps2_16[24];
                    rx16++;
                    checks++;
                    if (q16.size() == 0) begin
                        errors++;
                        $display("FAIL pkt16: got %h required no packet", ps2_16);
                    end else begin
                        exp_pkt = q16.pop_front();
                        if (ps2_16 !== exp_pkt) begin
                            errors++;
                            $display("FAIL pkt16: got %h required %h", ps2_16, exp_pkt);
                        end
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ps2_1", ps2_1, 25'h0);
        chk("reset_qe1", 25'(qe1), 25'h0);
        chk("reset_ps2_16", ps2_16, 25'h0);
        chk("reset_qe16", 25'(qe16), 25'h0);
        reset_n = 1'b1;

        // Static inputs for three report periods.
        repeat (3) wait_phase(16, 0);
        wait_phase(16, 2);
        chk("idle_ps2", ps2_1, 25'h0);
        chk("idle_qe", 25'(qe1), 25'h0);

        // Four positive X steps.
        wait_phase(16, 0);
        push1({8'h00, 8'h04, 8'h08});
        for (int i = 0; i < 4; i++) begin
            xin1 = pos_next(xin1);
            @(posedge clk);
            @(posedge clk);
            #1;
        end

        // Two negative Y steps, then a quiet period.
        wait_phase(16, 0);
        push1({8'hFE, 8'h00, 8'h28});
        yin1 = 2'b01;
        @(posedge clk);
        @(posedge clk);
        #1;
        yin1 = 2'b11;
        wait_phase(16, 0);
        wait_phase(16, 0);
        wait_phase(16, 3);
        chk("quiet_toggle", 25'(ps2_1[24]), 25'(tog1));

        // Left button press, hold, release.
        wait_phase(16, 0);
        push1({8'h00, 8'h00, 8'h09});
        bl1 = 1'b0;
        wait_phase(16, 0);
        wait_phase(16, 0);
        push1({8'h00, 8'h00, 8'h08});
        bl1 = 1'b1;

        // Illegal X transition 00->11.
        wait_phase(16, 0);
        xin1 = 2'b11;
        repeat (4) @(posedge clk);
        #1;
        chk("quad_error_set", 25'(qe1), 25'h1);

        // Positive step decoded exactly in the wrap cycle lands in the following report.
        wait_phase(16, 13);
        rx_before = rx1;
        push1({8'h00, 8'h01, 8'h08});
        xin1 = 2'b01;
        wait_phase(16, 3);
        chk("wrap_step_deferred", 25'(rx1), 25'(rx_before));
        wait_phase(16, 3);
        chk("wrap_step_reported", 25'(rx1), 25'(rx_before + 1));

        // STEP=16: 20 positive steps saturate X at +255 with overflow.
        wait_phase(32, 0);
        push16({8'h00, 8'hFF, 8'h48});
        for (int i = 0; i < 20; i++) begin
            xin16 = pos_next(xin16);
            @(posedge clk);
            #1;
        end
        wait_phase(32, 0);
        push16({8'h00, 8'h00, 8'h09});
        bl16 = 1'b0;
        wait_phase(32, 0);
        push16({8'h00, 8'h00, 8'h08});
        bl16 = 1'b1;
        wait_phase(32, 0);
        wait_phase(32, 3);

        // Reset with a pending count discards it.
        wait_phase(16, 0);
        xin1 = pos_next(xin1);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_ps2_1", ps2_1, 25'h0);
        chk("midreset_qe1", 25'(qe1), 25'h0);
        chk("midreset_ps2_16", ps2_16, 25'h0);
        chk("midreset_qe16", 25'(qe16), 25'h0);
        reset_n = 1'b1;
        wait_phase(16, 0);
        wait_phase(16, 0);
        wait_phase(16, 3);
        chk("post_reset_ps2_1", ps2_1, 25'h0);
        chk("post_reset_ps2_16", ps2_16, 25'h0);

        chk("q1_drained", 25'(q1.size()), 25'h0);
        chk("q16_drained", 25'(q16.size()), 25'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
